// File: rtl/jtlt_sched_pkg.sv
// Shared types and helpers for the JTLT channel scheduler.
package jtlt_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GUARD = 1'b1
    } state_t;

    localparam int CT_CYCLES_DEF    = 2;
    localparam int MAX_INFLIGHT_DEF = 3;

    // Widest requester vector rr_pick can handle; callers zero-extend into it.
    localparam int RR_MAX   = 32;
    localparam int RR_IDX_W = 5;

    // One-hot winner: first set bit of req at or after ptr, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
        logic [RR_MAX-1:0] win;
        logic              found;
        int unsigned       idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((i < n) && !found && req[idx[RR_IDX_W-1:0]]) begin
                win[idx[RR_IDX_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/jtlt_channel_sched_if.sv
// Requester/channel bundle between the clocked control side and the scheduler.
interface jtlt_channel_sched_if #(
    parameter int N_REQ  = 4,
    parameter int INFL_W = 2
);
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic              tx_q;
    logic              rx_q;
    logic [INFL_W-1:0] inflight;
    logic              busy;
    logic              err;

    modport master (
        output req, rx_q,
        input  gnt, tx_q, inflight, busy, err
    );

    modport slave (
        input  req, rx_q,
        output gnt, tx_q, inflight, busy, err
    );
endinterface

// File: rtl/jtlt_rr_arbiter.sv
// Round-robin winner selection with the registered search pointer.
module jtlt_rr_arbiter
    import jtlt_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] win_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;
    logic [RR_MAX-1:0] pick_s;

    // Winner lookup and pointer advance to the slot after the winner.
    always_comb begin
        pick_s = rr_pick(RR_MAX'(req_i), int'(unsigned'(ptr_q)), N_REQ);
        win_o  = pick_s[N_REQ-1:0];
        ptr_d  = ptr_q;
        if (advance_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (win_o[i]) begin
                    ptr_d = (i == N_REQ - 1) ? PTR_W'(0) : PTR_W'(i + 1);
                end else begin
                    ptr_d = ptr_d;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_W'(0);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/jtlt_channel_sched.sv
// Shares one JTLT toggle channel between requesters: round-robin grant,
// critical-time guard after each pulse, and in-flight tracking via returned toggles.
module jtlt_channel_sched
    import jtlt_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CT_CYCLES    = CT_CYCLES_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int INFL_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input logic                 clk,
    input logic                 rst,
    jtlt_channel_sched_if.slave bus
);
    localparam int CNT_W = $clog2(CT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              toggle_q, toggle_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rx_prev_q;
    logic              issue_s;
    logic              ret_s;
    logic [N_REQ-1:0]  win_s;

    jtlt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req),
        .advance_i (issue_s),
        .win_o     (win_s)
    );

    // FSM, guard countdown, toggle and in-flight next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        toggle_d   = toggle_q;
        issue_s    = 1'b0;
        ret_s      = bus.rx_q ^ rx_prev_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if ((|bus.req) && (inflight_q < INFL_W'(MAX_INFLIGHT))) begin
                    issue_s  = 1'b1;
                    gnt_d    = win_s;
                    toggle_d = ~toggle_q;
                    cnt_d    = CNT_W'(CT_CYCLES);
                    state_d  = GUARD;
                end else begin
                    state_d = IDLE;
                end
            end
            GUARD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = GUARD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A return with nothing in flight is a protocol error and is discarded.
        if (ret_s && (inflight_q == INFL_W'(0))) begin
            err_d      = 1'b1;
            inflight_d = issue_s ? INFL_W'(1) : INFL_W'(0);
        end else if (ret_s && !issue_s) begin
            inflight_d = inflight_q - INFL_W'(1);
        end else if (issue_s && !ret_s) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else begin
            inflight_d = inflight_q;
        end

        busy_d = (state_d == GUARD) || (inflight_d != INFL_W'(0));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_W'(0);
            gnt_q      <= '0;
            toggle_q   <= 1'b0;
            inflight_q <= INFL_W'(0);
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rx_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            toggle_q   <= toggle_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rx_prev_q  <= bus.rx_q;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.tx_q     = toggle_q;
    assign bus.inflight = inflight_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_jtlt_channel_sched.sv
// Bench for jtlt_channel_sched: fixed vector table, corner-case sequences and
// random traffic compared against a countdown/modulo reference model.
module tb_jtlt_channel_sched;
    localparam int N    = 4;
    localparam int CT   = 2;
    localparam int MAXI = 3;
    localparam int IW   = $clog2(MAXI + 1);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    jtlt_channel_sched_if #(.N_REQ(N), .INFL_W(IW)) bus ();

    jtlt_channel_sched #(.N_REQ(N), .CT_CYCLES(CT), .MAX_INFLIGHT(MAXI), .INFL_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int         m_guard, m_ptr, m_infl;
    bit         m_tx, m_err, m_rxp, m_busy;
    logic [3:0] m_gnt;

    typedef struct {
        logic [3:0] req;
        logic       rx;
        logic [3:0] gnt;
        logic       tx;
        logic [1:0] infl;
        logic       busy;
        logic       err;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic t,
                              input int inf, input logic b, input logic e);
        chk({tag, ".gnt"}, int'(bus.gnt), int'(g));
        chk({tag, ".tx"}, int'(bus.tx_q), int'(t));
        chk({tag, ".inflight"}, int'(bus.inflight), inf);
        chk({tag, ".busy"}, int'(bus.busy), int'(b));
        chk({tag, ".err"}, int'(bus.err), int'(e));
    endtask

    task automatic model_reset();
        m_guard = 0; m_ptr = 0; m_infl = 0;
        m_tx = 0; m_err = 0; m_rxp = 0; m_busy = 0; m_gnt = '0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic x);
        bit ret, issue;
        int w;
        ret   = (x != m_rxp);
        m_rxp = x;
        issue = (m_guard == 0) && (r != 4'd0) && (m_infl < MAXI);
        m_gnt = '0;
        if (issue) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            m_gnt[w] = 1'b1;
            m_ptr    = (w + 1) % N;
            m_tx     = !m_tx;
            m_guard  = CT;
        end else if (m_guard > 0) begin
            m_guard--;
        end
        if (ret && m_infl == 0) m_err = 1;
        else if (ret) m_infl--;
        if (issue) m_infl++;
        m_busy = (m_guard > 0) || (m_infl > 0);
    endtask

    task automatic drive_edge(input logic [3:0] r, input logic x);
        @(negedge clk);
        bus.req  = r;
        bus.rx_q = x;
        @(posedge clk);
        model_edge(r, x);
        #1;
    endtask

    task automatic step_m(input string tag, input logic [3:0] r, input logic x);
        drive_edge(r, x);
        check_outs(tag, m_gnt, m_tx, m_infl, m_busy, m_err);
    endtask

    // Asserted 1 time unit after an edge, so mid-cycle and independent of clk.
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        bus.req  = '0;
        bus.rx_q = 1'b0;
        #1;
        check_outs(tag, 4'd0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int   gcount;
        logic rx;
        logic [3:0] r;

        tbl[0]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1};

        rst      = 1'b0;
        bus.req  = '0;
        bus.rx_q = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset0");

        // Single request, round-robin with returns, spurious return.
        for (int i = 0; i < 15; i++) begin
            drive_edge(tbl[i].req, tbl[i].rx);
            check_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].tx,
                       int'(tbl[i].infl), tbl[i].busy, tbl[i].err);
        end

        // Full stall: three grants, then none until a return frees a slot.
        do_reset("reset1");
        gcount = 0;
        for (int i = 0; i < 12; i++) begin
            step_m("stall", 4'b0001, 1'b0);
            if (bus.gnt != 4'd0) gcount++;
        end
        chk("stall_grants", gcount, 3);
        chk("stall_inflight", int'(bus.inflight), 3);
        step_m("stall_ret", 4'b0001, 1'b1);
        chk("stall_ret_nogrant", int'(bus.gnt), 0);
        chk("stall_ret_inflight", int'(bus.inflight), 2);
        step_m("stall_4th", 4'b0001, 1'b1);
        chk("stall_4th_gnt", int'(bus.gnt), 1);

        // Simultaneous issue and return with one pulse in flight.
        step_m("drain", 4'b0000, 1'b0);
        step_m("drain", 4'b0000, 1'b1);
        step_m("drain", 4'b0000, 1'b1);
        chk("simul_pre_inflight", int'(bus.inflight), 1);
        step_m("simul", 4'b0001, 1'b0);
        chk("simul_gnt", int'(bus.gnt), 1);
        chk("simul_inflight", int'(bus.inflight), 1);

        // Reset in the middle of a guard interval with two pulses in flight.
        do_reset("reset2");
        step_m("mg", 4'b0001, 1'b0);
        step_m("mg", 4'b0001, 1'b0);
        step_m("mg", 4'b0001, 1'b0);
        step_m("mg", 4'b0001, 1'b0);
        step_m("mg", 4'b0001, 1'b1);
        step_m("mg", 4'b0001, 1'b1);
        step_m("mg", 4'b0001, 1'b1);
        step_m("mg", 4'b0000, 1'b1);
        chk("mg_pre_tx", int'(bus.tx_q), 1);
        chk("mg_pre_inflight", int'(bus.inflight), 2);
        chk("mg_pre_busy", int'(bus.busy), 1);
        do_reset("mg_reset");
        step_m("mg_post", 4'b0100, 1'b0);
        chk("mg_post_gnt", int'(bus.gnt), 4);
        step_m("mg_post", 4'b0000, 1'b0);
        step_m("mg_post", 4'b0000, 1'b0);
        step_m("mg_post", 4'b1011, 1'b0);
        chk("mg_post_rr", int'(bus.gnt), 8);

        // Random traffic against the reference model.
        do_reset("reset3");
        rx = 1'b0;
        r  = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
            if (m_infl > 0 && $urandom_range(0, 3) == 0) rx = ~rx;
            else if ($urandom_range(0, 99) == 0) rx = ~rx;
            step_m("rand", r, rx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtlt_channel_sched.md
# jtlt_channel_sched

Clocked scheduler that shares one JTLT pulse transmission channel between `N_REQ` requesters. Each grant issues one SFQ pulse, encoded as a toggle on the channel's input line `a`. Grants are round-robin. After every pulse the channel's critical-timing window is enforced as a guard interval, and pulses in flight are tracked by counting toggles returned from the far end. The block sits between the clocked control logic and the cell-level JTLT chain, so the transmission cells never see a critical-timing violation.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `CT_CYCLES`, 2: guard cycles after each issued pulse, ≥1. Covers the cell critical time (6.6 ps) rounded up to whole clocks.
- `MAX_INFLIGHT`, 3: maximum number of issued pulses not yet returned, ≥1.
- `INFL_W`, `$clog2(MAX_INFLIGHT+1)`: width of the in-flight counter (derived).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  `N_REQ`  level request, one bit per requester.
- `gnt`  out  `N_REQ`  one-hot grant, single-cycle pulse.
- `tx_q`  out  1  toggle line driving JTLT input `a`; each issued pulse inverts it.
- `rx_q`  in  1  far-end toggle line, already synchronous to `clk`.
- `inflight`  out  `INFL_W`  count of issued pulses not yet returned.
- `busy`  out  1  high when `state==GUARD` or `inflight!=0`.
- `err`  out  1  sticky protocol error.

## Operation
- **FSM states:** `IDLE` and `GUARD`.
- **Issue in `IDLE`:** a pulse is issued when `|req` is true and registered `inflight < MAX_INFLIGHT`. One issue means all of:
  - the round-robin winner's `gnt` bit is set;
  - `tx_q` is inverted;
  - `inflight` is incremented;
  - the guard counter is loaded with `CT_CYCLES`;
  - the FSM moves to `GUARD`.
- **`GUARD`:** no grants. The counter decrements once per cycle. At the edge where it reaches 0 the FSM returns to `IDLE`.
- **Round-robin:** the pointer starts at 0. After granting requester `i`, the search starts at `(i+1) mod N_REQ`. With no grant, the pointer does not move.
- **Requester rules:** hold `req` until `gnt` is seen; dropping `req` before grant withdraws it without error. One grant equals exactly one pulse. A requester wanting k pulses keeps `req` high through k grants.
- **Return detection:** register `rx_prev`; a return is `rx_q ^ rx_prev`, and each return decrements `inflight`.
- **Simultaneous issue and return:** `inflight` is unchanged.
- **Full (`inflight == MAX_INFLIGHT`):** no grant. A return in the same cycle does not free a slot until the next cycle (the decision uses the registered count).
- **Return with `inflight == 0`:** `err` is set, `inflight` stays 0. `err` clears only on `rst`.
- **Reset, any time, async:**
  - `gnt=0`, `tx_q=0`, `inflight=0`, `err=0`, `busy=0`;
  - `state=IDLE`, pointer 0, `rx_prev=0`;
  - pending pulses are forgotten.
  
  The far-end chain must also be reset so that `rx_q=0` while `rst` is high.

## Timing
- Inputs are sampled at rising edge k. `gnt` and the `tx_q` toggle are registered at edge k and valid for cycle k→k+1.
- Request-to-grant latency: 1 edge when idle.
- Minimum spacing between grants: `CT_CYCLES+1` edges. With a continuous request and free slots, grants land at edges k, k+3, k+6, … for `CT_CYCLES=2`.
- `inflight`, `busy` and `err` are registered and reflect all events up to and including the current edge.
- No combinational path from inputs to outputs.

## Structure
- **Package `jtlt_sched_pkg`:**
  - `state_t` enum {`IDLE`, `GUARD`};
  - function `rr_pick(req, ptr)` returning a one-hot winner;
  - default localparams for `CT_CYCLES` and `MAX_INFLIGHT`.
- **Sub-module `jtlt_rr_arbiter`:** combinational winner selection plus the registered pointer, instantiated once. The FSM, guard counter, toggle logic and in-flight counter stay in the top module.

## Test plan
- **Single request:** reset, then `req=4'b0010` at edge 1 → `gnt=0010` at edge 1, `tx_q` 0→1, `inflight=1`, `busy=1`. Next grant no earlier than edge 4.
- **Round-robin:** `req=4'b1111` held, `rx_q` toggled 2 cycles after each grant → grants 0001, 0010, 0100, 1000, 0001 spaced 3 edges apart; `inflight` never exceeds 1.
- **Full stall:** `MAX_INFLIGHT=3`, `req=4'b0001` held, no returns → exactly 3 grants, then `gnt=0` indefinitely. One `rx_q` toggle → 4th grant at the first `IDLE` edge after the toggle edge.
- **Simultaneous issue and return:** `inflight=1`, grant and `rx_q` toggle on the same edge → `inflight` stays 1.
- **Spurious return:** `inflight=0`, toggle `rx_q` → `err=1` next edge, `inflight=0`, `err` held until `rst`.
- **Reset mid-guard:** assert `rst` during `GUARD` with `inflight=2`, `tx_q=1` → immediately `tx_q=0`, `inflight=0`, `gnt=0`. After release, `req=4'b0100` is granted after 1 edge with pointer restarted at 0.
